// File: rtl/mem_sp_sync_if.sv
// mem_sp_sync_if: access bus for the single-port synchronous RAM.
//   i_w_cs     chip select (driven by master)
//   i_w_we     write enable, 1 = write, 0 = read (driven by master)
//   i_w_addr   word address (driven by master)
//   i_w_wdata  write data (driven by master)
//   o_w_rdata  registered read data (driven by the RAM)
interface mem_sp_sync_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  i_w_cs;
  logic                  i_w_we;
  logic [ADDR_WIDTH-1:0] i_w_addr;
  logic [DATA_WIDTH-1:0] i_w_wdata;
  logic [DATA_WIDTH-1:0] o_w_rdata;

  modport master (
    output i_w_cs, i_w_we, i_w_addr, i_w_wdata,
    input  o_w_rdata
  );

  modport slave (
    input  i_w_cs, i_w_we, i_w_addr, i_w_wdata,
    output o_w_rdata
  );
endinterface

// File: rtl/mem_sp_sync.sv
// mem_sp_sync: single-port synchronous RAM, 2^ADDR_WIDTH words of
// DATA_WIDTH bits, one shared address, registered read (1-cycle latency).
//   i_w_clk    clock, rising edge
//   i_w_rst_n  asynchronous active-low reset; clears the read register only
//   bus        mem_sp_sync_if.slave: cs, we, addr, wdata in; rdata out
module mem_sp_sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic           i_w_clk,
  input logic           i_w_rst_n,
  mem_sp_sync_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign w_wr_en = bus.i_w_cs &  bus.i_w_we;
  assign w_rd_en = bus.i_w_cs & ~bus.i_w_we;

  // The array has no reset so it keeps its contents through reset; the
  // reset level is still checked here so edges during reset never write.
  always_ff @(posedge i_w_clk) begin
    if (i_w_rst_n && w_wr_en) begin
      r_mem[bus.i_w_addr] <= bus.i_w_wdata;
    end
  end

  // Writes and idle cycles hold the output; there is no write-through.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[bus.i_w_addr];
    end
  end

  assign bus.o_w_rdata = r_rdata;

endmodule

// File: tb/tb_mem_sp_sync.sv
module tb_mem_sp_sync;

  logic clk;
  logic rst_n;

  mem_sp_sync_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  mem_sp_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference model: word array plus a written flag per word
  logic [7:0] mdl [256];
  bit         mdl_wr [256];
  logic [7:0] exp_rd;
  bit         exp_known;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // drive one access, clock it, update the model, compare the output
  task automatic step(input string tag, input bit cs, input bit we,
                      input logic [7:0] addr, input logic [7:0] wdata);
    bus.i_w_cs    = cs;
    bus.i_w_we    = we;
    bus.i_w_addr  = addr;
    bus.i_w_wdata = wdata;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_rd    = 8'h00;
      exp_known = 1'b1;
    end else if (cs && we) begin
      mdl[addr]    = wdata;
      mdl_wr[addr] = 1'b1;
    end else if (cs) begin
      exp_rd    = mdl[addr];
      exp_known = mdl_wr[addr];
    end
    if (exp_known) chk(tag, bus.o_w_rdata, exp_rd);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_rd    = 8'h00;
    exp_known = 1'b1;
    for (int i = 0; i < 256; i++) mdl_wr[i] = 1'b0;
    bus.i_w_cs    = 1'b0;
    bus.i_w_we    = 1'b0;
    bus.i_w_addr  = 8'h00;
    bus.i_w_wdata = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("reset_init", bus.o_w_rdata, 8'h00);
    step("in_reset", 1'b0, 1'b0, 8'h00, 8'h00);
    #2 rst_n = 1'b1;

    // basic write/read
    step("wr_10", 1'b1, 1'b1, 8'h10, 8'hAA);
    step("rd_10", 1'b1, 1'b0, 8'h10, 8'h00);
    chk("basic_10", bus.o_w_rdata, 8'hAA);
    step("wr_2a", 1'b1, 1'b1, 8'h2A, 8'hBB);
    step("rd_2a", 1'b1, 1'b0, 8'h2A, 8'h00);
    chk("basic_2a", bus.o_w_rdata, 8'hBB);
    step("rd_10b", 1'b1, 1'b0, 8'h10, 8'h33);
    chk("basic_10_again", bus.o_w_rdata, 8'hAA);

    // reset mid-cycle: output clears without a clock, array survives,
    // and a write attempted during reset is ignored
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", bus.o_w_rdata, 8'h00);
    exp_rd = 8'h00;
    step("wr_in_reset", 1'b1, 1'b1, 8'h10, 8'h77);
    step("rd_in_reset", 1'b1, 1'b0, 8'h10, 8'h00);
    #2 rst_n = 1'b1;
    step("rd_after_reset", 1'b1, 1'b0, 8'h10, 8'h00);
    chk("array_survives", bus.o_w_rdata, 8'hAA);

    // overwrite
    step("ow_10", 1'b1, 1'b1, 8'h10, 8'hCC);
    step("rd_ow", 1'b1, 1'b0, 8'h10, 8'h00);
    chk("overwrite", bus.o_w_rdata, 8'hCC);

    // cs gating: idle cycle with we=1 must neither write nor change output
    step("idle_we", 1'b0, 1'b1, 8'h30, 8'hFF);
    chk("idle_hold", bus.o_w_rdata, 8'hCC);
    step("rd_30", 1'b1, 1'b0, 8'h30, 8'h00);  // unwritten word: value unchecked

    // write does not disturb output
    step("rd_2a_b", 1'b1, 1'b0, 8'h2A, 8'h00);
    chk("pre_write", bus.o_w_rdata, 8'hBB);
    step("wr_40", 1'b1, 1'b1, 8'h40, 8'h55);
    chk("write_hold", bus.o_w_rdata, 8'hBB);
    step("rd_40", 1'b1, 1'b0, 8'h40, 8'h00);
    chk("rd_40_val", bus.o_w_rdata, 8'h55);

    // boundaries and back-to-back
    step("wr_00", 1'b1, 1'b1, 8'h00, 8'h01);
    step("wr_ff", 1'b1, 1'b1, 8'hFF, 8'hFE);
    step("rd_ff", 1'b1, 1'b0, 8'hFF, 8'h00);
    chk("max_addr", bus.o_w_rdata, 8'hFE);
    step("rd_00", 1'b1, 1'b0, 8'h00, 8'h00);
    chk("min_addr", bus.o_w_rdata, 8'h01);
    step("rd_00_rep", 1'b1, 1'b0, 8'h00, 8'h00);
    chk("repeat_read", bus.o_w_rdata, 8'h01);

    // randomized traffic over a small address window so reads hit often
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15)) | ((($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00));
      step("rand", ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
           a, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
